time_divider_prog: RTL and testbench

//   Runtime-programmable successor to time_divider. Divides i_CLK by a divisor that can be

---
 rtl/time_divider_pkg.sv | 21 ++
 rtl/time_divider_prog_if.sv | 35 +++
 rtl/time_divider_cfg.sv | 63 ++++++
 rtl/time_divider_prog.sv | 80 ++++++++
 tb/tb_time_divider_prog.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/time_divider_pkg.sv
// ----------------------------------------------------------------------------
// time_divider_pkg
//   Shared constants and helpers for the programmable clock divider.
//   DIV_MIN     : smallest divisor the hardware will run with.
//   low_len()   : number of cycles o_CLK spends low in one period (ceil half).
//   clamp_div() : maps a requested divisor onto the legal range.
//   Helpers work on 32-bit values; callers cast to and from their own width.
// ----------------------------------------------------------------------------
package time_divider_pkg;

    localparam int unsigned DIV_MIN = 2;

    function automatic int unsigned low_len(input int unsigned div);
        return div - (div >> 1);
    endfunction

    function automatic int unsigned clamp_div(input int unsigned div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction

endpackage

// File: rtl/time_divider_prog_if.sv
// ----------------------------------------------------------------------------
// time_divider_prog_if
//   Control/status bundle of the programmable divider.
//   i_EN      : count enable
//   i_DIV     : requested divisor
//   i_DIV_LD  : one-cycle load strobe for i_DIV
//   o_CLK     : divided clock (registered)
//   o_TICK    : one-cycle pulse in the first high cycle of o_CLK
//   o_CNT     : current phase count
//   o_PEND    : a loaded divisor waits for the next period boundary
//   o_DIV_ACK : one-cycle pulse when a new divisor becomes active
//   master = controller side, slave = divider side.
// ----------------------------------------------------------------------------
interface time_divider_prog_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_EN;
    logic [CNT_W-1:0] i_DIV;
    logic             i_DIV_LD;
    logic             o_CLK;
    logic             o_TICK;
    logic [CNT_W-1:0] o_CNT;
    logic             o_PEND;
    logic             o_DIV_ACK;

    modport master (
        output i_EN, i_DIV, i_DIV_LD,
        input  o_CLK, o_TICK, o_CNT, o_PEND, o_DIV_ACK
    );

    modport slave (
        input  i_EN, i_DIV, i_DIV_LD,
        output o_CLK, o_TICK, o_CNT, o_PEND, o_DIV_ACK
    );
endinterface

// File: rtl/time_divider_cfg.sv
// ----------------------------------------------------------------------------
// time_divider_cfg
//   Divisor configuration: holds the shadow divisor, clamps requests, tracks
//   the pending flag and swaps the shadow into the active divisor on a wrap.
//   i_CLK, i_RST : system clock, synchronous active-high reset
//   i_DIV        : requested divisor
//   i_DIV_LD     : load strobe
//   i_WRAP       : enabled wrap of the phase counter (period boundary)
//   o_DIV_ACT    : divisor currently in effect
//   o_PEND       : shadow waiting to be applied
//   o_DIV_ACK    : one-cycle pulse after the shadow has been applied
// ----------------------------------------------------------------------------
module time_divider_cfg
    import time_divider_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 10
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [CNT_W-1:0] i_DIV,
    input  logic             i_DIV_LD,
    input  logic             i_WRAP,
    output logic [CNT_W-1:0] o_DIV_ACT,
    output logic             o_PEND,
    output logic             o_DIV_ACK
);

    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_ack;
    logic [CNT_W-1:0] w_div_clamped;

    assign w_div_clamped = CNT_W'(clamp_div(32'(i_DIV)));

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_div_act <= CNT_W'(DEF_DIV);
            r_shadow  <= CNT_W'(DEF_DIV);
            r_pend    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            // Apply reads the pre-edge shadow, so a load on the wrap edge is
            // not applied now; it re-arms the pending flag for the next wrap.
            if (i_WRAP && r_pend) begin
                r_div_act <= r_shadow;
                r_pend    <= 1'b0;
                r_ack     <= 1'b1;
            end
            if (i_DIV_LD) begin
                r_shadow <= w_div_clamped;
                r_pend   <= 1'b1;
            end
        end
    end

    assign o_DIV_ACT = r_div_act;
    assign o_PEND    = r_pend;
    assign o_DIV_ACK = r_ack;

endmodule

// File: rtl/time_divider_prog.sv
// ----------------------------------------------------------------------------
// time_divider_prog
//   Runtime-programmable clock divider. Produces a registered divided clock,
//   a tick strobe at the rising phase and the live phase count. New divisors
//   are shadowed and take effect at a period boundary.
//   i_CLK : system clock (rising edge)
//   i_RST : synchronous active-high reset
//   bus   : slave side of time_divider_prog_if (enable, divisor load,
//           divided clock, tick, count, pending, ack)
// ----------------------------------------------------------------------------
module time_divider_prog
    import time_divider_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 10
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    time_divider_prog_if.slave  bus
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_act;
    logic [CNT_W-1:0] w_low_len;
    logic             w_last;
    logic             w_wrap;
    logic             w_pend;
    logic             w_ack;

    time_divider_cfg #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_cfg (
        .i_CLK     (i_CLK),
        .i_RST     (i_RST),
        .i_DIV     (bus.i_DIV),
        .i_DIV_LD  (bus.i_DIV_LD),
        .i_WRAP    (w_wrap),
        .o_DIV_ACT (w_div_act),
        .o_PEND    (w_pend),
        .o_DIV_ACK (w_ack)
    );

    assign w_low_len = CNT_W'(low_len(32'(w_div_act)));

    always_comb begin
        w_last    = (r_cnt == (w_div_act - CNT_W'(1)));
        w_wrap    = bus.i_EN & w_last;
        w_cnt_nxt = r_cnt;
        if (bus.i_EN) begin
            w_cnt_nxt = w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

    // o_CLK and o_TICK are decoded from the next count so they line up with
    // o_CNT in the same cycle. A divisor swap only happens when the next
    // count is 0, which is always in the low phase, so the current divisor
    // is safe to use here.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_clk  <= (w_cnt_nxt >= w_low_len);
            r_tick <= bus.i_EN && (w_cnt_nxt == w_low_len);
        end
    end

    assign bus.o_CNT     = r_cnt;
    assign bus.o_CLK     = r_clk;
    assign bus.o_TICK    = r_tick;
    assign bus.o_PEND    = w_pend;
    assign bus.o_DIV_ACK = w_ack;

endmodule

// File: tb/tb_time_divider_prog.sv
// ----------------------------------------------------------------------------
// tb_time_divider_prog
//   Bench for time_divider_prog: directed scenarios followed by random
//   enable/load/reset traffic, all compared every cycle with a behavioural
//   reference model of the divider.
// ----------------------------------------------------------------------------
module tb_time_divider_prog;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEF_DIV = 10;

    logic clk;
    logic rst;

    time_divider_prog_if #(.CNT_W(CNT_W)) bus ();

    time_divider_prog #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    // Reference model state
    int unsigned m_cnt   = 0;
    int unsigned m_act   = DEF_DIV;
    int unsigned m_sh    = DEF_DIV;
    bit          m_pend  = 0;
    bit          m_ack   = 0;
    bit          m_tick  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: present inputs, let the edge happen, advance the model by
    // the divider rules, then compare every output.
    task automatic cyc(input bit en, input bit ld, input int unsigned div, input bit r);
        int unsigned old_act;
        bit          wrap;
        rst          = r;
        bus.i_EN     = en;
        bus.i_DIV_LD = ld;
        bus.i_DIV    = CNT_W'(div);
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_act = DEF_DIV; m_sh = DEF_DIV;
            m_pend = 0; m_ack = 0; m_tick = 0;
        end else begin
            old_act = m_act;
            wrap    = en && (m_cnt == m_act - 1);
            m_ack   = 0;
            m_tick  = 0;
            if (wrap && m_pend) begin
                m_act  = m_sh;
                m_pend = 0;
                m_ack  = 1;
            end
            if (ld) begin
                m_sh   = (div < 2) ? 2 : div;
                m_pend = 1;
            end
            if (en) begin
                m_cnt  = wrap ? 0 : m_cnt + 1;
                m_tick = (m_cnt == old_act - old_act / 2);
            end
        end
        #1;
        chk("cnt",  32'(bus.o_CNT), m_cnt);
        chk("clk",  32'(bus.o_CLK), 32'(m_cnt >= m_act - m_act / 2));
        chk("tick", 32'(bus.o_TICK), 32'(m_tick));
        chk("pend", 32'(bus.o_PEND), 32'(m_pend));
        chk("ack",  32'(bus.o_DIV_ACK), 32'(m_ack));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    // Advance with EN=1 until the DUT shows the requested count, bounded.
    task automatic advance_to(input int unsigned target);
        for (int i = 0; i < 200; i++) begin
            if (bus.o_CNT == CNT_W'(target)) break;
            cyc(1, 0, 0, 0);
        end
        chk("advance_bound", 32'(bus.o_CNT), target);
    endtask

    initial begin
        rst          = 1'b1;
        bus.i_EN     = 1'b0;
        bus.i_DIV    = '0;
        bus.i_DIV_LD = 1'b0;

        // Reset state
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // Default divisor 10: 5 low / 5 high
        run(40);

        // Load 7 mid-period; applies at the wrap
        advance_to(3);
        cyc(1, 1, 7, 0);
        run(30);

        // Loads below the minimum clamp to 2
        cyc(1, 1, 0, 0);
        run(12);
        cyc(1, 1, 1, 0);
        run(12);

        // Back to 10, then freeze at count 4
        cyc(1, 1, 10, 0);
        run(20);
        advance_to(4);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
        run(5);

        // Last load wins; single ack
        cyc(1, 1, 5, 0);
        cyc(1, 1, 12, 0);
        run(30);
        // Load on a wrap edge stays pending for one more period
        advance_to(11);
        cyc(1, 1, 9, 0);
        run(30);

        // Reset while a load is pending
        cyc(1, 1, 6, 0);
        advance_to(8);
        cyc(1, 0, 0, 1);
        run(25);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          en;
            bit          ld;
            bit          r;
            int unsigned dv;
            en = ($urandom_range(0, 4) != 0);
            ld = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 299) == 0);
            dv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
            cyc(en, ld, dv, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
